// File: rtl/rtc_pkg.sv
// Shared RTC register map and bus-reader state encoding.
// The read-address sequencer uses the same constants.
package rtc_pkg;

  localparam logic [7:0] ADDR_SEG   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HORA  = 8'h23;
  localparam logic [7:0] ADDR_DIA   = 8'h24;
  localparam logic [7:0] ADDR_MES   = 8'h25;
  localparam logic [7:0] ADDR_ANIO  = 8'h26;
  localparam logic [7:0] ADDR_DSEM  = 8'h27;
  localparam logic [7:0] ADDR_NSEM  = 8'h28;
  localparam logic [7:0] ADDR_TSEG  = 8'h41;
  localparam logic [7:0] ADDR_TMIN  = 8'h42;
  localparam logic [7:0] ADDR_THORA = 8'h43;

  localparam int NUM_SHADOW = 11;
  localparam logic [3:0] NO_SHADOW = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_END,
    ST_GAP,
    ST_READ,
    ST_READ_END
  } rtc_state_e;

  // Map a register address to its shadow slot; NO_SHADOW when not decoded.
  function automatic logic [3:0] shadow_index(input logic [7:0] a);
    logic [3:0] idx;
    idx = NO_SHADOW;
    case (a)
      ADDR_SEG:   idx = 4'd0;
      ADDR_MIN:   idx = 4'd1;
      ADDR_HORA:  idx = 4'd2;
      ADDR_DIA:   idx = 4'd3;
      ADDR_MES:   idx = 4'd4;
      ADDR_ANIO:  idx = 4'd5;
      ADDR_DSEM:  idx = 4'd6;
      ADDR_NSEM:  idx = 4'd7;
      ADDR_TSEG:  idx = 4'd8;
      ADDR_TMIN:  idx = 4'd9;
      ADDR_THORA: idx = 4'd10;
      default:    idx = NO_SHADOW;
    endcase
    return idx;
  endfunction

  function automatic logic addr_decoded(input logic [7:0] a);
    return shadow_index(a) != NO_SHADOW;
  endfunction

endpackage

// File: rtl/rtc_bus_reader_if.sv
// Multiplexed address/data pad bundle of the RTC parallel bus.
// master = bus-cycle engine, slave = RTC side (pad read-back).
interface rtc_bus_reader_if;

  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ad_sel;

  modport master (
    input  ad_in,
    output ad_out, ad_oe, cs_n, rd_n, wr_n, ad_sel
  );

  modport slave (
    output ad_in,
    input  ad_out, ad_oe, cs_n, rd_n, wr_n, ad_sel
  );

endinterface

// File: rtl/rtc_shadow_regs.sv
// Address-decoded shadow register file holding the raw BCD bytes read from the RTC.
module rtc_shadow_regs
  import rtc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] dsem,
  output logic [7:0] nsem,
  output logic [7:0] t_seg,
  output logic [7:0] t_min,
  output logic [7:0] t_hora
);

  logic [7:0] regs_q [NUM_SHADOW];
  logic [7:0] regs_d [NUM_SHADOW];
  logic [3:0] widx;

  always_comb begin
    regs_d = regs_q;
    widx   = shadow_index(waddr);
    if (we && (widx < 4'(NUM_SHADOW))) begin
      regs_d[widx] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: 8'h00};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign seg    = regs_q[0];
  assign min    = regs_q[1];
  assign hora   = regs_q[2];
  assign dia    = regs_q[3];
  assign mes    = regs_q[4];
  assign anio   = regs_q[5];
  assign dsem   = regs_q[6];
  assign nsem   = regs_q[7];
  assign t_seg  = regs_q[8];
  assign t_min  = regs_q[9];
  assign t_hora = regs_q[10];

endmodule

// File: rtl/rtc_bus_reader.sv
// Runs one multiplexed address/data read cycle per new sequencer address and
// captures the returned byte into the matching shadow register.
module rtc_bus_reader
  import rtc_pkg::*;
#(
  parameter int T_PHASE = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       addr,
  input  logic             addr_valid,
  rtc_bus_reader_if.master bus,
  output logic             busy,
  output logic             data_stb,
  output logic [7:0]       seg,
  output logic [7:0]       min,
  output logic [7:0]       hora,
  output logic [7:0]       dia,
  output logic [7:0]       mes,
  output logic [7:0]       anio,
  output logic [7:0]       dsem,
  output logic [7:0]       nsem,
  output logic [7:0]       t_seg,
  output logic [7:0]       t_min,
  output logic [7:0]       t_hora
);

  localparam int CW = $clog2(T_PHASE);
  localparam logic [CW-1:0] PH_LAST = CW'(T_PHASE - 1);

  rtc_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] cur_addr_q, cur_addr_d;
  logic [7:0] last_addr_q, last_addr_d;
  logic [7:0] sample_q, sample_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic ad_oe_q, ad_oe_d;
  logic cs_n_q, cs_n_d;
  logic rd_n_q, rd_n_d;
  logic wr_n_q, wr_n_d;
  logic ad_sel_q, ad_sel_d;
  logic busy_q, busy_d;
  logic data_stb_q, data_stb_d;
  logic phase_done;
  logic shadow_we;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    cur_addr_d  = cur_addr_q;
    last_addr_d = last_addr_q;
    sample_d    = sample_q;
    data_stb_d  = 1'b0;
    shadow_we   = 1'b0;
    phase_done  = (cnt_q == PH_LAST);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!addr_valid) begin
          last_addr_d = 8'h00;
        end else if (addr != last_addr_q) begin
          last_addr_d = addr;
          if (addr_decoded(addr)) begin
            cur_addr_d = addr;
            state_d    = ST_ADDR;
          end
        end
      end
      ST_ADDR:     if (phase_done) state_d = ST_ADDR_END;
      ST_ADDR_END: if (phase_done) state_d = ST_GAP;
      ST_GAP:      if (phase_done) state_d = ST_READ;
      ST_READ: begin
        if (phase_done) begin
          sample_d = bus.ad_in;
          state_d  = ST_READ_END;
        end
      end
      ST_READ_END: begin
        if (phase_done) begin
          shadow_we  = 1'b1;
          data_stb_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Strobes are decoded from the next state so they are registered with it.
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_sel_d = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = 8'h00;
    busy_d   = (state_d != ST_IDLE);
    case (state_d)
      ST_ADDR: begin
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        ad_sel_d = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = cur_addr_d;
      end
      ST_ADDR_END: begin
        ad_sel_d = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = cur_addr_d;
      end
      ST_READ: begin
        cs_n_d = 1'b0;
        rd_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_addr_q  <= 8'h00;
      last_addr_q <= 8'h00;
      sample_q    <= 8'h00;
      ad_out_q    <= 8'h00;
      ad_oe_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      ad_sel_q    <= 1'b1;
      busy_q      <= 1'b0;
      data_stb_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_addr_q  <= cur_addr_d;
      last_addr_q <= last_addr_d;
      sample_q    <= sample_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      ad_sel_q    <= ad_sel_d;
      busy_q      <= busy_d;
      data_stb_q  <= data_stb_d;
    end
  end

  assign bus.ad_out = ad_out_q;
  assign bus.ad_oe  = ad_oe_q;
  assign bus.cs_n   = cs_n_q;
  assign bus.rd_n   = rd_n_q;
  assign bus.wr_n   = wr_n_q;
  assign bus.ad_sel = ad_sel_q;
  assign busy       = busy_q;
  assign data_stb   = data_stb_q;

  rtc_shadow_regs u_shadow (
    .clk    (clk),
    .reset  (reset),
    .we     (shadow_we),
    .waddr  (cur_addr_q),
    .wdata  (sample_q),
    .seg    (seg),
    .min    (min),
    .hora   (hora),
    .dia    (dia),
    .mes    (mes),
    .anio   (anio),
    .dsem   (dsem),
    .nsem   (nsem),
    .t_seg  (t_seg),
    .t_min  (t_min),
    .t_hora (t_hora)
  );

endmodule
